// File: rtl/dec_n_seq.sv
// Registered N-to-2^N one-hot decoder with latch, timed-pulse and scan modes.
// Define DEC_N_SEQ_ERR_EN to add the err output and reject codes above MAX_CODE.
module dec_n_seq #(
    parameter int N         = 4,
    parameter int PULSE_LEN = 4,
    parameter int SCAN_DIV  = 8,
    parameter int MAX_CODE  = (1 << N) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      code,
    output logic [(1<<N)-1:0] out,
    output logic              out_valid,
    output logic              busy
`ifdef DEC_N_SEQ_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int OW = 1 << N;
    localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [N-1:0]  IDX_LAST = N'(MAX_CODE);

    typedef enum logic [1:0] {
        MODE_LATCH = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    mode_e          mode_q, mode_d;
    logic [OW-1:0]  out_q, out_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [DW-1:0]  div_q, div_d;

    logic           mode_chg;
    logic           xfer;
    logic           code_ok;
    logic [OW-1:0]  dec;

    assign mode_chg = (mode_e'(mode) != mode_q);
    assign dec      = OW'(1) << code;

    always_comb begin
        in_ready = 1'b0;
        if (!rst && en) begin
            in_ready = (mode == MODE_LATCH) ||
                       ((mode == MODE_PULSE) && !busy_q);
        end
    end

    assign xfer = in_valid && in_ready;

`ifdef DEC_N_SEQ_ERR_EN
    assign code_ok = (int'(code) <= MAX_CODE);
`else
    assign code_ok = 1'b1;
`endif

    always_comb begin
        mode_d = mode_q;
        out_d  = out_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        div_d  = div_q;
        if (en) begin
            mode_d = mode_e'(mode);
            if (mode_chg) begin
                // A mode switch aborts everything; new mode runs next edge.
                out_d  = '0;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                div_d  = '0;
            end else begin
                unique case (mode_q)
                    MODE_LATCH: begin
                        if (xfer && code_ok) begin
                            out_d = dec;
                        end
                    end
                    MODE_PULSE: begin
                        if (busy_q) begin
                            if (cnt_q == '0) begin
                                out_d  = '0;
                                busy_d = 1'b0;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                        end else if (xfer && code_ok) begin
                            out_d  = dec;
                            busy_d = 1'b1;
                            cnt_d  = CNT_LOAD;
                        end
                    end
                    MODE_SCAN: begin
                        out_d = OW'(1) << idx_q;
                        if (div_q == DIV_LAST) begin
                            div_d = '0;
                            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                    MODE_RSVD: begin
                        out_d = '0;
                    end
                    default: begin
                        out_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_LATCH;
            out_q  <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            idx_q  <= '0;
            div_q  <= '0;
        end else begin
            mode_q <= mode_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            div_q  <= div_d;
        end
    end

`ifdef DEC_N_SEQ_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (en) begin
            err_d = xfer && !code_ok && !mode_chg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign out       = out_q;
    assign out_valid = |out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dec_n_seq.sv
// Directed bench for dec_n_seq: behavioural model feeds a scoreboard queue.
// Builds with or without DEC_N_SEQ_ERR_EN.
module tb_dec_n_seq;

    localparam int N  = 4;
    localparam int PL = 4;
    localparam int SD = 2;
`ifdef DEC_N_SEQ_ERR_EN
    localparam int MAXC   = 9;
    localparam bit ERR_ON = 1'b1;
`else
    localparam int MAXC   = 2;
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, in_valid;
    logic [1:0]  mode;
    logic [N-1:0] code;
    logic        in_ready, out_valid, busy, err;
    logic [15:0] out;

    always #5 clk = ~clk;

    dec_n_seq #(
        .N(N), .PULSE_LEN(PL), .SCAN_DIV(SD), .MAX_CODE(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .code(code),
        .out(out), .out_valid(out_valid), .busy(busy)
`ifdef DEC_N_SEQ_ERR_EN
        , .err(err)
`endif
    );

`ifndef DEC_N_SEQ_ERR_EN
    assign err = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] o;
        logic        b;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] m_out  = '0;
    logic        m_busy = 1'b0;
    logic        m_err  = 1'b0;
    logic [1:0]  m_prev = 2'b00;
    int          m_rem  = 0;
    int          m_idx  = 0;
    int          m_div  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_rdy();
        return !rst && en && (mode == 2'b00 || (mode == 2'b01 && !m_busy));
    endfunction

    task automatic model_edge();
        logic take, bad;
        take = in_valid && model_rdy();
        bad  = ERR_ON && (int'(code) > MAXC);
        if (rst) begin
            m_out = '0; m_busy = 0; m_err = 0; m_prev = 2'b00;
            m_rem = 0; m_idx = 0; m_div = 0;
        end else if (en) begin
            m_err = 1'b0;
            if (mode != m_prev) begin
                m_prev = mode;
                m_out = '0; m_busy = 0; m_rem = 0; m_idx = 0; m_div = 0;
            end else begin
                case (mode)
                    2'b00: begin
                        if (take && bad) m_err = 1'b1;
                        else if (take) m_out = 16'h1 << code;
                    end
                    2'b01: begin
                        if (m_busy) begin
                            m_rem--;
                            if (m_rem == 0) begin
                                m_out = '0;
                                m_busy = 1'b0;
                            end
                        end else if (take && bad) begin
                            m_err = 1'b1;
                        end else if (take) begin
                            m_out = 16'h1 << code;
                            m_busy = 1'b1;
                            m_rem = PL;
                        end
                    end
                    2'b10: begin
                        m_out = 16'h1 << m_idx;
                        m_div++;
                        if (m_div == SD) begin
                            m_div = 0;
                            m_idx = (m_idx == MAXC) ? 0 : m_idx + 1;
                        end
                    end
                    default: m_out = '0;
                endcase
            end
        end
    endtask

    task automatic step();
        exp_t e;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, model_rdy()});
        model_edge();
        sb.push_back({m_out, m_busy, m_err});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out", {16'd0, out}, {16'd0, e.o});
        chk("out_valid", {31'd0, out_valid}, {31'd0, |e.o});
        chk("busy", {31'd0, busy}, {31'd0, e.b});
        chk("err", {31'd0, err}, {31'd0, e.e});
    endtask

    initial begin
        rst = 1; en = 1; mode = 2'b00; in_valid = 1; code = 4'd1;
        repeat (2) step();
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        rst = 0; in_valid = 0;
        step();

        // latch
        in_valid = 1; code = 4'd5;
        step();
        chk("latch5", {16'd0, out}, 32'h0020);
        code = 4'd15;
        step();
        chk("latch15", {16'd0, out}, 32'h8000);
        in_valid = 0;
        repeat (2) step();
        chk("latch_hold", {16'd0, out}, 32'h8000);

        // pulse with held in_valid
        mode = 2'b01;
        step();
        in_valid = 1; code = 4'd3;
        step();
        chk("pulse3", {16'd0, out}, 32'h0008);
        chk("pulse_busy", {31'd0, busy}, 32'd1);
        code = 4'd7;
        repeat (6) step();
        chk("pulse_next", {16'd0, out}, 32'h0080);
        in_valid = 0;
        repeat (5) step();

        // mode change mid-pulse
        in_valid = 1; code = 4'd2;
        step();
        in_valid = 0;
        step();
        mode = 2'b00;
        step();
        chk("abort_out", {16'd0, out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        in_valid = 1; code = 4'd4;
        step();
        chk("after_abort", {16'd0, out}, 32'h0010);

        // latch back-to-back
        for (int i = 0; i < 8; i++) begin
            code = N'($urandom_range(0, 15));
            step();
        end
        in_valid = 0;

        // scan with a freeze
        mode = 2'b10; in_valid = 1;
        repeat (5) step();
        en = 0;
        repeat (3) step();
        en = 1;
        repeat (8) step();

        // reset mid-scan
        rst = 1;
        step();
        chk("rst_scan", {16'd0, out}, 32'd0);
        rst = 0;
        repeat (3) step();

        // reserved mode
        mode = 2'b11;
        repeat (3) step();

        // mode change while disabled
        mode = 2'b00; en = 0;
        repeat (2) step();
        en = 1;
        step();

        // pulse frozen by en
        mode = 2'b01; in_valid = 0;
        step();
        in_valid = 1; code = 4'd9;
        step();
        in_valid = 0; en = 0;
        repeat (2) step();
        en = 1;
        repeat (5) step();

        // out-of-range code
        mode = 2'b00;
        step();
        in_valid = 1; code = 4'd1;
        step();
        code = 4'd12;
        step();
`ifdef DEC_N_SEQ_ERR_EN
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_hold", {16'd0, out}, 32'h0002);
`else
        chk("big_code", {16'd0, out}, 32'h1000);
`endif
        code = 4'd9;
        step();
        chk("code9", {16'd0, out}, 32'h0200);
        chk("err_clr", {31'd0, err}, 32'd0);
        in_valid = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
